shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit storage register between four requesters. Each requester issues a single read or write transaction through a req/gnt/ack handshake. The block owns the register, serialises all accesses to it, and returns the register contents with every acknowledge. It sits between the control units that share a working register and the register itself, and replaces direct write-enable/data wiring to that register.

## Interface
- WIDTH, 16, register and data width in bits
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- req  input  4  per-requester transaction request, bit i = requester i
- we  input  4  per-requester write select (1 = write, 0 = read); sampled at grant
- wdata  input  4*WIDTH  write data, requester i on bits [i*WIDTH +: WIDTH]; sampled at grant
- lock  input  4  per-requester lock request (used only with ARB_LOCK_EN)
- gnt  output  4  one-hot grant, high for exactly one cycle per transaction
- ack  output  1  one-cycle completion pulse
- ack_id  output  2  index of the requester being acknowledged, valid with ack
- rdata  output  WIDTH  register value after the transaction, valid with ack
- busy  output  1  high whenever the state is not IDLE

## Operation
- State machine: IDLE, ACCESS, DONE.
- IDLE:
  - If req is non-zero, select the winner by round-robin. The search starts at ptr+1 and wraps modulo 4.
  - Latch the winner index, we[winner] and wdata[winner].
  - Assert gnt[winner] and go to ACCESS.
  - If req is zero, stay in IDLE.
- ACCESS:
  - On a latched write, the register takes the latched wdata.
  - On a read, the register is unchanged.
  - ptr takes the winner index. Go to DONE.
- DONE:
  - Pulse ack with ack_id = winner.
  - rdata = the register value, which already includes the write when the transaction was a write.
  - Go to IDLE.
- Requesters hold req until they see their own gnt bit. After gnt, req may drop; the latched transaction still completes.
- A req bit that is still high in the IDLE cycle after that requester's ack is a new transaction.
- No transaction is ever lost: any requester with req held high is granted within 4 transactions (round-robin fairness).
- rdata holds its last value between acks.
- Reset values: state IDLE, ptr 3 (requester 0 has first priority), register 0, gnt 0, ack 0, ack_id 0, rdata 0, busy 0.
- Reset has priority over every other action. An active-low reset at any edge sends the FSM to IDLE and zeroes the register. A write pending in ACCESS at that edge is not committed and no ack is produced.

## Timing
- Edge E0 samples req non-zero while in IDLE. gnt is high from E0 to E1, busy rises at E0.
- The write commits at E1.
- ack, ack_id and rdata are valid from E2 to E3. busy falls at E3.
- Transaction latency is 3 cycles from the req sample to the ack sample. Maximum throughput is 1 transaction per 3 cycles.
- Simultaneous requests: exactly one gnt bit is high per transaction. The others wait, with no change to the register.
- A requester that asserts req during ACCESS or DONE is first sampled in the next IDLE cycle.

## Configuration
- ARB_LOCK_EN defined:
  - If lock[winner] is high in the DONE cycle and req[winner] is high in the following IDLE cycle, that requester is regranted without round-robin. ptr is not advanced past it, so atomic read-modify-write sequences are possible.
  - A lock is held for at most 4 consecutive transactions. After that, round-robin is forced for one arbitration.
- ARB_LOCK_EN undefined: the lock input is present but ignored, and pure round-robin applies.

## Test plan
- Reset, then requester 0 writes 65 with req=0001, we=0001 → gnt=0001 one cycle later, ack with ack_id=0 and rdata=65 two cycles after that.
- All four requesters request at once. Writes 32, 241, 73, 16 come from requesters 0 to 3 respectively → grants occur in order 0, 1, 2, 3, and the final rdata is 16.
- Requester 2 writes 25, then requester 1 reads → requester 1's ack shows rdata=25 and the register is unchanged.
- Requester 3 writes 123, and reset is driven low in the ACCESS cycle → no ack, the register reads 0 afterwards, and ptr=3 (the next sole requester 0 is granted first).
- Requesters 0 and 1 hold req continuously → gnt alternates 0, 1, 0, 1, and no requester is granted twice in a row.
- With ARB_LOCK_EN defined, requester 1 holds lock and req while requester 2 holds req → requester 1 receives 4 consecutive grants, then requester 2 is granted. Without the macro, grants alternate 1, 2.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/sequencer owning one WIDTH-bit register shared by four requesters.
// Optional `ARB_LOCK_EN: a locked winner is regranted for up to 4 consecutive transactions.
module shared_reg_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req,
    input  logic [3:0]         we,
    input  logic [4*WIDTH-1:0] wdata,
    input  logic [3:0]         lock,
    output logic [3:0]         gnt,
    output logic               ack,
    output logic [1:0]         ack_id,
    output logic [WIDTH-1:0]   rdata,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    // Handshake: a requester holds req until it sees its own gnt bit (one cycle);
    // the latched transaction then completes with a one-cycle ack carrying ack_id/rdata.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, win_idx, pick, sel_idx;
    logic             pick_valid, grant_go, regrant;
    logic             win_we;
    logic [WIDTH-1:0] win_wdata, reg_q;
    logic [3:0]       gnt_nxt;
    logic             ack_nxt;

    // Nearest requester after ptr wins; scanning far-to-near lets the nearest overwrite.
    always_comb begin
        logic [1:0] idx;
        idx        = ptr;
        pick       = ptr;
        pick_valid = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

`ifdef ARB_LOCK_EN
    logic       lock_valid;
    logic [2:0] run_cnt;

    assign regrant = lock_valid && req[win_idx];

    // lock_valid is only honoured in the single IDLE cycle right after DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_valid <= 1'b0;
            run_cnt    <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    lock_valid <= 1'b0;
                    if (grant_go)
                        run_cnt <= regrant ? run_cnt + 3'd1 : 3'd1;
                end
                DONE:    lock_valid <= lock[win_idx] && (run_cnt < 3'd4);
                default: ;
            endcase
        end
    end
`else
    logic lock_unused;
    assign lock_unused = ^lock;
    assign regrant     = 1'b0;
`endif

    assign sel_idx  = regrant ? win_idx : pick;
    assign grant_go = regrant || pick_valid;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_go) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt = 4'b0000;
        ack_nxt = 1'b0;
        if (state == IDLE && grant_go) gnt_nxt = 4'b0001 << sel_idx;
        if (state == DONE)             ack_nxt = 1'b1;
    end

    // gnt/ack are registered, so ack lands in the IDLE cycle that follows DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            gnt       <= 4'b0000;
            ack       <= 1'b0;
            ack_id    <= 2'd0;
            rdata     <= '0;
            ptr       <= 2'd3;
            win_idx   <= 2'd0;
            win_we    <= 1'b0;
            win_wdata <= '0;
            reg_q     <= '0;
        end else begin
            gnt <= gnt_nxt;
            ack <= ack_nxt;
            case (state)
                IDLE: if (grant_go) begin
                    win_idx   <= sel_idx;
                    win_we    <= we[sel_idx];
                    win_wdata <= wdata[int'(sel_idx)*WIDTH +: WIDTH];
                end
                ACCESS: begin
                    if (win_we) reg_q <= win_wdata;
                    ptr <= win_idx;
                end
                DONE: begin
                    ack_id <= win_idx;
                    rdata  <= reg_q;
                end
                default: ;
            endcase
        end
    end

    // busy also covers the ack cycle so it spans the whole transaction.
    assign busy      = (state != IDLE) || ack;
    assign state_dbg = state;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter: reset, writes/reads, arbitration
// order, reset during ACCESS, fairness and the optional lock behaviour.
module tb_shared_reg_arbiter;

    localparam int WIDTH = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         req, we, lock;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         gnt;
    logic               ack, busy;
    logic [1:0]         ack_id, state_dbg;
    logic [WIDTH-1:0]   rdata;

    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .wdata(wdata), .lock(lock),
        .gnt(gnt), .ack(ack), .ack_id(ack_id), .rdata(rdata), .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b0; req = '0; we = '0; lock = '0; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt !== 4'b0000) begin
                g = gnt;
                break;
            end
        end
    endtask

    task automatic wait_ack(output logic seen, output logic [1:0] id, output logic [WIDTH-1:0] d);
        seen = 1'b0; id = 2'd0; d = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack === 1'b1) begin
                seen = 1'b1; id = ack_id; d = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (ack_id !== 2'd0) begin errors++; $display("FAIL reset_ack_id got %0d exp 0", ack_id); end
        checks++; if (rdata !== 16'd0) begin errors++; $display("FAIL reset_rdata got %0d exp 0", rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_dbg); end
    endtask

    task automatic test_single_write();
        req = 4'b0001; we = 4'b0001; wdata = '0; wdata[15:0] = 16'd65;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sw_gnt got %b exp 0001", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sw_busy_rise got %b exp 1", busy); end
        req = '0; we = '0;
        @(negedge clk);
        checks++; if ({gnt, ack} !== 5'b0) begin errors++; $display("FAIL sw_e1_quiet got gnt %b ack %b exp 0", gnt, ack); end
        @(negedge clk);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL sw_ack got %b exp 1", ack); end
        checks++; if (ack_id !== 2'd0) begin errors++; $display("FAIL sw_ack_id got %0d exp 0", ack_id); end
        checks++; if (rdata !== 16'd65) begin errors++; $display("FAIL sw_rdata got %0d exp 65", rdata); end
        @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sw_ack_pulse got %b exp 0", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_fall got %b exp 0", busy); end
        checks++; if (rdata !== 16'd65) begin errors++; $display("FAIL sw_rdata_hold got %0d exp 65", rdata); end
    endtask

    task automatic test_all_four();
        logic [3:0]       g;
        logic             seen;
        logic [1:0]       id;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] vals [4];
        vals = '{16'd32, 16'd241, 16'd73, 16'd16};
        apply_reset();
        req = 4'b1111; we = 4'b1111;
        for (int i = 0; i < 4; i++) wdata[i*WIDTH +: WIDTH] = vals[i];
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g);
            checks++; if (g !== (4'b0001 << i)) begin errors++; $display("FAIL all4_gnt%0d got %b exp %b", i, g, 4'b0001 << i); end
            req[i] = 1'b0;
            wait_ack(seen, id, d);
            checks++; if (!seen || id !== 2'(i) || d !== vals[i]) begin
                errors++; $display("FAIL all4_ack%0d got seen %b id %0d rdata %0d exp id %0d rdata %0d", i, seen, id, d, i, vals[i]);
            end
        end
        we = '0;
        checks++; if (rdata !== 16'd16) begin errors++; $display("FAIL all4_final got %0d exp 16", rdata); end
    endtask

    task automatic test_read_after_write();
        logic [3:0]       g;
        logic             seen;
        logic [1:0]       id;
        logic [WIDTH-1:0] d;
        req = 4'b0100; we = 4'b0100; wdata = '0; wdata[2*WIDTH +: WIDTH] = 16'd25;
        wait_gnt(g);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL raw_w_gnt got %b exp 0100", g); end
        req = '0; we = '0;
        wait_ack(seen, id, d);
        checks++; if (!seen || id !== 2'd2 || d !== 16'd25) begin errors++; $display("FAIL raw_w_ack got id %0d rdata %0d exp id 2 rdata 25", id, d); end
        req = 4'b0010; we = 4'b0000; wdata[1*WIDTH +: WIDTH] = 16'hBEEF;
        wait_gnt(g);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL raw_r_gnt got %b exp 0010", g); end
        req = '0;
        wait_ack(seen, id, d);
        checks++; if (!seen || id !== 2'd1 || d !== 16'd25) begin errors++; $display("FAIL raw_r_ack got id %0d rdata %0d exp id 1 rdata 25", id, d); end
        req = 4'b0001; wdata[15:0] = 16'h1234;
        wait_gnt(g);
        req = '0;
        wait_ack(seen, id, d);
        checks++; if (!seen || id !== 2'd0 || d !== 16'd25) begin errors++; $display("FAIL raw_r2_ack got id %0d rdata %0d exp id 0 rdata 25", id, d); end
    endtask

    task automatic test_reset_in_access();
        logic [3:0]       g;
        logic             seen;
        logic [1:0]       id;
        logic [WIDTH-1:0] d;
        int               stray_acks;
        req = 4'b1000; we = 4'b1000; wdata = '0; wdata[3*WIDTH +: WIDTH] = 16'd123;
        wait_gnt(g);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL rst_acc_gnt got %b exp 1000", g); end
        reset = 1'b0; req = '0; we = '0;
        @(negedge clk);
        checks++; if (state_dbg !== 2'd0 || busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++; $display("FAIL rst_acc_idle got state %0d busy %b gnt %b exp 0 0 0000", state_dbg, busy, gnt);
        end
        reset = 1'b1;
        stray_acks = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack === 1'b1) stray_acks++;
        end
        checks++; if (stray_acks !== 0) begin errors++; $display("FAIL rst_acc_no_ack got %0d acks exp 0", stray_acks); end
        req = 4'b1001; we = 4'b0000;
        wait_gnt(g);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL rst_acc_ptr got %b exp 0001", g); end
        req[0] = 1'b0;
        wait_ack(seen, id, d);
        checks++; if (!seen || id !== 2'd0 || d !== 16'd0) begin errors++; $display("FAIL rst_acc_reg got id %0d rdata %0d exp id 0 rdata 0", id, d); end
        wait_gnt(g);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL rst_acc_next got %b exp 1000", g); end
        req = '0;
        wait_ack(seen, id, d);
        checks++; if (!seen || id !== 2'd3 || d !== 16'd0) begin errors++; $display("FAIL rst_acc_reg3 got id %0d rdata %0d exp id 3 rdata 0", id, d); end
    endtask

    task automatic test_fair_pair();
        logic [3:0]       g;
        logic             seen;
        logic [1:0]       id;
        logic [WIDTH-1:0] d;
        // ptr is 3 after the last grant, so requester 0 goes first.
        req = 4'b0011; we = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(g);
            checks++; if (g !== ((i % 2 == 0) ? 4'b0001 : 4'b0010)) begin
                errors++; $display("FAIL fair_gnt%0d got %b exp %b", i, g, (i % 2 == 0) ? 4'b0001 : 4'b0010);
            end
        end
        req = '0;
        wait_ack(seen, id, d);
        checks++; if (!seen || id !== 2'd1) begin errors++; $display("FAIL fair_last_ack got seen %b id %0d exp id 1", seen, id); end
    endtask

    task automatic test_lock();
        logic [3:0]       g;
        logic             seen;
        logic [1:0]       id;
        logic [WIDTH-1:0] d;
        logic [3:0]       exp_g [5];
`ifdef ARB_LOCK_EN
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
`else
        exp_g = '{4'b0010, 4'b0100, 4'b0010, 4'b0100, 4'b0010};
`endif
        apply_reset();
        req = 4'b0110; lock = 4'b0010; we = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g);
            checks++; if (g !== exp_g[i]) begin errors++; $display("FAIL lock_gnt%0d got %b exp %b", i, g, exp_g[i]); end
        end
        req = '0; lock = '0;
        wait_ack(seen, id, d);
        checks++; if (!seen) begin errors++; $display("FAIL lock_drain got no ack exp ack"); end
    endtask

    initial begin
        reset = 1'b0; req = '0; we = '0; lock = '0; wdata = '0;
        test_reset();
        test_single_write();
        test_all_four();
        test_read_after_write();
        test_reset_in_access();
        test_fair_pair();
        test_lock();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
